// File: rtl/axi4_fb_pkg.sv
// Shared AXI4 encodings, framebuffer layout constants and the read-slave state type.
// The response classifier is shared so every AR channel user agrees on error priority.
package axi4_fb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B = 3'b011;

  localparam logic [31:0] FB0_ADDR = 32'h81000000;
  localparam logic [31:0] FB1_ADDR = 32'h8112c000;
  localparam logic [31:0] FB_BYTES = 32'h0012c000;

  typedef enum logic {
    IDLE,
    RUN
  } slave_state_t;

  // Decode errors outrank burst-type errors.
  function automatic logic [1:0] classify_resp(
    input logic       decerr,
    input logic [1:0] burst,
    input logic [2:0] size
  );
    if (decerr) begin
      return RESP_DECERR;
    end
    if ((burst != BURST_INCR) || (size != SIZE_8B)) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/fb_sdp_bram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Read-first: a same-address read and write in one cycle returns the old word.
module fb_sdp_bram #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_fb_read_slave.sv
// AXI4 read-only slave returning 64-bit INCR bursts from an internal framebuffer RAM.
// One burst at a time; reads run one word ahead into a 2-entry skid FIFO feeding R.
module axi4_fb_read_slave
  import axi4_fb_pkg::*;
#(
  parameter int unsigned C_S00_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 64,
  parameter logic [C_S00_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h81000000,
  parameter logic [31:0] C_WIN_BYTES = 32'h00258000,
  localparam int unsigned DEPTH   = C_WIN_BYTES / 8,
  localparam int unsigned LOAD_AW = $clog2(DEPTH)
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic [2:0]                      s00_axi_arsize,
  input  logic [1:0]                      s00_axi_arburst,
  input  logic                            s00_axi_arlock,
  input  logic [3:0]                      s00_axi_arcache,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic [3:0]                      s00_axi_arqos,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            load_en,
  input  logic [LOAD_AW-1:0]              load_addr,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] load_data,
  output logic                            busy,
  output logic                            error
);

  localparam int unsigned AWP = C_S00_AXI_ADDR_WIDTH + 1;
  localparam logic [AWP-1:0] DEPTH_W = AWP'(DEPTH);
  localparam int unsigned DW = C_S00_AXI_DATA_WIDTH;

  slave_state_t r_state;
  slave_state_t w_state_next;

  logic                          r_arready;
  logic [C_S00_AXI_ID_WIDTH-1:0] r_id;
  logic [7:0]                    r_len;
  logic [1:0]                    r_resp;
  logic                          r_error;
  logic [LOAD_AW-1:0]            r_rd_addr;
  logic [8:0]                    r_iss_cnt;
  logic [7:0]                    r_beat_cnt;
  logic                          r_pipe_vld;
  logic                          r_pipe_last;
  logic [DW-1:0]                 r_f0_data;
  logic                          r_f0_last;
  logic [DW-1:0]                 r_f1_data;
  logic                          r_f1_last;
  logic [1:0]                    r_fcnt;

  logic [C_S00_AXI_ADDR_WIDTH-1:0] w_off;
  logic [AWP-1:0]                  w_start_word;
  logic [AWP-1:0]                  w_end_word;
  logic                            w_decerr;
  logic [1:0]                      w_ar_resp;
  logic                            w_ar_hs;
  logic                            w_pop;
  logic                            w_last_hs;
  logic [1:0]                      w_outstanding;
  logic                            w_room;
  logic                            w_more;
  logic                            w_issue;
  logic                            w_issue_last;
  logic                            w_rd_en;
  logic [LOAD_AW-1:0]              w_rd_addr;
  logic [DW-1:0]                   w_ram_q;
  logic [DW-1:0]                   w_push_data;
  logic                            w_unused_ok;

  // Burst end is computed one bit wider so a window overrun can never wrap back in range.
  assign w_off        = s00_axi_araddr - C_BASE_ADDR;
  assign w_start_word = {4'b0000, w_off[C_S00_AXI_ADDR_WIDTH-1:3]};
  assign w_end_word   = w_start_word + AWP'(s00_axi_arlen);
  assign w_decerr     = (s00_axi_araddr < C_BASE_ADDR) || (w_end_word >= DEPTH_W);
  assign w_ar_resp    = classify_resp(w_decerr, s00_axi_arburst, s00_axi_arsize);

  assign w_ar_hs       = s00_axi_arvalid && r_arready;
  assign w_pop         = (r_fcnt != 2'd0) && s00_axi_rready;
  assign w_last_hs     = w_pop && (r_beat_cnt == r_len);
  assign w_outstanding = r_fcnt + {1'b0, r_pipe_vld};
  assign w_room        = (w_outstanding - {1'b0, w_pop}) < 2'd2;
  assign w_more        = r_iss_cnt <= {1'b0, r_len};

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_rd_addr;
    case (r_state)
      IDLE: begin
        if (w_ar_hs) begin
          w_state_next = RUN;
          w_issue      = 1'b1;
          w_issue_last = (s00_axi_arlen == 8'd0);
          w_rd_en      = (w_ar_resp == RESP_OKAY);
          w_rd_addr    = w_start_word[LOAD_AW-1:0];
        end
      end
      RUN: begin
        if (w_more && w_room) begin
          w_issue      = 1'b1;
          w_issue_last = (r_iss_cnt[7:0] == r_len);
          w_rd_en      = (r_resp == RESP_OKAY);
        end
        if (w_last_hs) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_state     <= IDLE;
      r_arready   <= 1'b0;
      r_id        <= '0;
      r_len       <= 8'd0;
      r_resp      <= RESP_OKAY;
      r_error     <= 1'b0;
      r_rd_addr   <= '0;
      r_iss_cnt   <= 9'd0;
      r_beat_cnt  <= 8'd0;
      r_pipe_vld  <= 1'b0;
      r_pipe_last <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_arready   <= (w_state_next == IDLE);
      r_pipe_vld  <= w_issue;
      r_pipe_last <= w_issue_last;
      if (w_issue) begin
        r_rd_addr <= w_rd_addr + 1'b1;
      end
      if (w_ar_hs) begin
        r_id       <= s00_axi_arid;
        r_len      <= s00_axi_arlen;
        r_resp     <= w_ar_resp;
        r_iss_cnt  <= 9'd1;
        r_beat_cnt <= 8'd0;
        if (w_ar_resp != RESP_OKAY) begin
          r_error <= 1'b1;
        end
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + 9'd1;
        end
        if (w_pop) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
        end
      end
    end
  end

  // Error bursts never enable the RAM, so their beats carry zero data.
  assign w_push_data = (r_resp == RESP_OKAY) ? w_ram_q : '0;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_f0_data <= '0;
      r_f0_last <= 1'b0;
      r_f1_data <= '0;
      r_f1_last <= 1'b0;
      r_fcnt    <= 2'd0;
    end else if (r_pipe_vld && w_pop) begin
      if (r_fcnt == 2'd2) begin
        r_f0_data <= r_f1_data;
        r_f0_last <= r_f1_last;
        r_f1_data <= w_push_data;
        r_f1_last <= r_pipe_last;
      end else begin
        r_f0_data <= w_push_data;
        r_f0_last <= r_pipe_last;
      end
    end else if (r_pipe_vld) begin
      if (r_fcnt == 2'd0) begin
        r_f0_data <= w_push_data;
        r_f0_last <= r_pipe_last;
      end else begin
        r_f1_data <= w_push_data;
        r_f1_last <= r_pipe_last;
      end
      r_fcnt <= r_fcnt + 2'd1;
    end else if (w_pop) begin
      if (r_fcnt == 2'd2) begin
        r_f0_data <= r_f1_data;
        r_f0_last <= r_f1_last;
      end
      r_fcnt <= r_fcnt - 2'd1;
    end
  end

  fb_sdp_bram #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (LOAD_AW)
  ) u_bram (
    .clk    (s00_axi_aclk),
    .i_we   (load_en),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_re   (w_rd_en),
    .i_raddr(w_rd_addr),
    .o_rdata(w_ram_q)
  );

  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = (r_fcnt != 2'd0);
  assign s00_axi_rdata   = r_f0_data;
  assign s00_axi_rlast   = r_f0_last && s00_axi_rvalid;
  assign s00_axi_rresp   = r_resp;
  assign s00_axi_rid     = r_id;
  assign busy            = (r_state == RUN);
  assign error           = r_error;

  assign w_unused_ok = ^{s00_axi_arlock, s00_axi_arcache, s00_axi_arprot, s00_axi_arqos, w_off[2:0]};

endmodule

// File: tb/tb_axi4_fb_read_slave.sv
// Directed bench for axi4_fb_read_slave: a table of bursts plus hand-written
// sequences for load-port timing and reset in the middle of a burst.
module tb_axi4_fb_read_slave;

  localparam logic [31:0] BASE   = 32'h81000000;
  localparam logic [1:0]  INCR   = 2'b01;
  localparam logic [1:0]  WRAP   = 2'b10;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;

  logic        clk;
  logic        areset;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [63:0] load_data;
  logic        busy;
  logic        error;

  axi4_fb_read_slave #(
    .C_WIN_BYTES(32'h00002000)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .s00_axi_arid   (arid),
    .s00_axi_araddr (araddr),
    .s00_axi_arlen  (arlen),
    .s00_axi_arsize (arsize),
    .s00_axi_arburst(arburst),
    .s00_axi_arlock (1'b0),
    .s00_axi_arcache(4'h0),
    .s00_axi_arprot (3'h0),
    .s00_axi_arqos  (4'h0),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rid    (rid),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rlast  (rlast),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .busy           (busy),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [0:0]  id;
    logic        bp;
    logic [1:0]  resp;
    logic [63:0] d0;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        exp_err = 1'b0;

  function automatic vec_t mk(logic [31:0] a, logic [7:0] l, logic [1:0] b, logic [2:0] s,
                              logic [0:0] i, logic p, logic [1:0] r, logic [63:0] d);
    vec_t v;
    v.addr = a; v.len = l; v.burst = b; v.size = s; v.id = i; v.bp = p; v.resp = r; v.d0 = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the last beat (or after beat abort_after).
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [0:0] id, input logic bp,
                          input logic [1:0] resp, input int abort_after, input logic ld,
                          input logic [9:0] la, input logic [63:0] ldd, input string tag);
    int  cyc;
    int  beat;
    int  guard;
    bit  seen;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    load_en = ld; load_addr = la; load_data = ldd;
    if (resp != OKAY) exp_err = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!arready) begin
      chk({tag, " ar_accept"}, 64'(arready), 64'd1);
      arvalid = 1'b0;
      load_en = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    load_en = 1'b0;
    chk({tag, " arready_drop"}, 64'(arready), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 1; beat = 0; guard = 0; seen = 0;
    while (beat <= int'(len) && guard < 2000) begin
      rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid) begin
        if (!seen) chk({tag, " first_rvalid_cycle"}, 64'(cyc), 64'd2);
        seen = 1;
        chk($sformatf("%s beat%0d rdata", tag, beat), rdata, exp_q[beat]);
        chk($sformatf("%s beat%0d rlast", tag, beat), 64'(rlast), 64'(beat == int'(len)));
        chk($sformatf("%s beat%0d rresp", tag, beat), 64'(rresp), 64'(resp));
        chk($sformatf("%s beat%0d rid", tag, beat), 64'(rid), 64'(id));
        chk($sformatf("%s beat%0d arready", tag, beat), 64'(arready), 64'd0);
        if (rready) begin
          beat++;
          if (abort_after >= 0 && beat == abort_after) begin
            @(negedge clk);
            rready = 1'b0;
            return;
          end
        end
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    rready = 1'b0;
    chk({tag, " beats_done"}, 64'(beat), 64'(int'(len) + 1));
    chk({tag, " arready_after"}, 64'(arready), 64'd1);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " rvalid_after"}, 64'(rvalid), 64'd0);
    chk({tag, " error"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arvalid = 1'b0; rready = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

    vecs[0]  = mk(BASE,               8'd63, INCR, 3'd3, 1'b1, 1'b0, OKAY,   64'd0);
    vecs[1]  = mk(BASE,               8'd63, INCR, 3'd3, 1'b0, 1'b1, OKAY,   64'd0);
    vecs[2]  = mk(BASE + 32'h1F8,     8'd0,  INCR, 3'd3, 1'b1, 1'b0, OKAY,   64'd63);
    vecs[3]  = mk(BASE + 32'h200,     8'd7,  INCR, 3'd3, 1'b0, 1'b0, OKAY,   64'd64);
    vecs[4]  = mk(BASE + 32'h1FF8,    8'd0,  INCR, 3'd3, 1'b1, 1'b0, OKAY,   64'd1023);
    vecs[5]  = mk(BASE + 32'h1FC0,    8'd7,  INCR, 3'd3, 1'b0, 1'b1, OKAY,   64'd1016);
    vecs[6]  = mk(BASE + 32'h7,       8'd1,  INCR, 3'd3, 1'b1, 1'b0, OKAY,   64'd0);
    vecs[7]  = mk(BASE + 32'h1FE0,    8'd4,  INCR, 3'd3, 1'b0, 1'b0, DECERR, 64'd0);
    vecs[8]  = mk(BASE + 32'h1FF8,    8'd3,  INCR, 3'd3, 1'b1, 1'b1, DECERR, 64'd0);
    vecs[9]  = mk(32'h80FFFFF8,       8'd0,  INCR, 3'd3, 1'b0, 1'b0, DECERR, 64'd0);
    vecs[10] = mk(BASE,               8'd3,  WRAP, 3'd3, 1'b1, 1'b0, SLVERR, 64'd0);
    vecs[11] = mk(BASE + 32'h40,      8'd1,  INCR, 3'd2, 1'b0, 1'b0, SLVERR, 64'd0);

    repeat (3) @(negedge clk);
    chk("reset arready", 64'(arready), 64'd0);
    chk("reset rvalid", 64'(rvalid), 64'd0);
    chk("reset rlast", 64'(rlast), 64'd0);
    chk("reset rdata", rdata, 64'd0);
    chk("reset rresp", 64'(rresp), 64'd0);
    chk("reset rid", 64'(rid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    areset = 1'b0;
    #1 chk("arready before first edge", 64'(arready), 64'd0);
    @(negedge clk);
    chk("arready after first edge", 64'(arready), 64'd1);

    for (int i = 0; i < 1024; i++) begin
      load_en = 1'b1; load_addr = 10'(i); load_data = 64'(i);
      @(negedge clk);
    end
    load_en = 1'b0;

    for (int v = 0; v < 12; v++) begin
      exp_q.delete();
      for (int k = 0; k <= int'(vecs[v].len); k++)
        exp_q.push_back((vecs[v].resp == OKAY) ? vecs[v].d0 + 64'(k) : 64'd0);
      do_burst(vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size, vecs[v].id, vecs[v].bp,
               vecs[v].resp, -1, 1'b0, 10'd0, 64'd0, $sformatf("vec%0d", v));
    end

    // Write to the word being read in the AR cycle: the old word comes back.
    exp_q.delete(); exp_q.push_back(64'd500);
    do_burst(BASE + 32'd4000, 8'd0, INCR, 3'd3, 1'b0, 1'b0, OKAY, -1, 1'b1, 10'd500,
             64'hCAFE_0000_0000_F00D, "ld_same_cycle");
    exp_q.delete(); exp_q.push_back(64'hCAFE_0000_0000_F00D);
    do_burst(BASE + 32'd4000, 8'd0, INCR, 3'd3, 1'b1, 1'b0, OKAY, -1, 1'b0, 10'd0, 64'd0,
             "ld_visible");
    // Write of the next word at the AR edge is seen by the following read issue.
    exp_q.delete(); exp_q.push_back(64'd510); exp_q.push_back(64'hBEEF);
    do_burst(BASE + 32'd4080, 8'd1, INCR, 3'd3, 1'b0, 1'b0, OKAY, -1, 1'b1, 10'd511,
             64'hBEEF, "ld_next_word");

    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(64'(k));
    do_burst(BASE, 8'd63, INCR, 3'd3, 1'b1, 1'b0, OKAY, 10, 1'b0, 10'd0, 64'd0, "pre_reset");
    #2 areset = 1'b1;
    exp_err = 1'b0;
    #1;
    chk("midreset rvalid", 64'(rvalid), 64'd0);
    chk("midreset arready", 64'(arready), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset error", 64'(error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    chk("post_reset arready", 64'(arready), 64'd1);
    do_burst(BASE, 8'd63, INCR, 3'd3, 1'b0, 1'b1, OKAY, -1, 1'b0, 10'd0, 64'd0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
